bcd4_to_binary_seq: RTL and testbench

Sequential 4-digit BCD-to-binary converter. It is the inverse of the team's combinational binary-to-BCD digit splitter. It turns four decimal digits (for example, keypad or score-entry digits) back into a 16-bit unsigned value, using the reverse double-dabble algorithm: shift right, then subtract 3. The algorithm runs one bit per clock, which keeps the logic small on the FPGA fabric next to the game-logic core.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_nibble_correct.sv | 17 +
 rtl/bcd4_to_binary_seq.sv | 92 +++++++++
 tb/tb_bcd4_to_binary_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the 4-digit BCD-to-binary converter.
// Provides the FSM state type, fixed sizes and the digit-validity helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DIGITS        = 4;
    localparam int BIN_W           = 16;
    localparam int N_ITER          = 16;
    localparam int NIB_CORR_THRESH = 8;
    localparam int NIB_CORR_SUB    = 3;
    localparam int WORK_W          = N_DIGITS * 4 + BIN_W;
    localparam int CNT_W           = 4;

    function automatic logic digit_invalid(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_nibble_correct.sv
// Per-digit correction step of reverse double-dabble:
// a nibble that reached 8 or more after the right shift gets 3 subtracted.
module bcd_nibble_correct
    import bcd_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    always_comb begin
        if (nib_in >= 4'(NIB_CORR_THRESH))
            nib_out = nib_in - 4'(NIB_CORR_SUB);
        else
            nib_out = nib_in;
    end

endmodule

// File: rtl/bcd4_to_binary_seq.sv
// Sequential 4-digit BCD to 16-bit binary converter, one shift/correct step per clock.
// A conversion takes 16 CONV cycles followed by a one-cycle DONE state.
module bcd4_to_binary_seq
    import bcd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  d0,
    input  logic [3:0]  d1,
    input  logic [3:0]  d2,
    input  logic [3:0]  d3,
    output logic        busy,
    output logic        done,
    output logic [15:0] binary,
    output logic        err
);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [WORK_W-1:0]   work_q;
    logic [WORK_W-1:0]   work_shift;
    logic [WORK_W-1:0]   work_next;
    logic                err_pend_q;
    logic [BIN_W-1:0]    binary_q;
    logic                err_q;
    logic [3:0]          corr [N_DIGITS];
    logic                accept;
    logic                last_iter;

    assign work_shift = work_q >> 1;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_corr
            bcd_nibble_correct u_corr (
                .nib_in  (work_shift[BIN_W + 4*gi +: 4]),
                .nib_out (corr[gi])
            );
        end
    endgenerate

    assign work_next = {corr[3], corr[2], corr[1], corr[0], work_shift[BIN_W-1:0]};

    // start is only honoured when no conversion is running
    assign accept    = start && (state_q != CONV);
    assign last_iter = (state_q == CONV) && (cnt_q == CNT_W'(N_ITER - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (last_iter) state_d = DONE;
            DONE:    state_d = start ? CONV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            err_pend_q <= 1'b0;
            binary_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                work_q     <= {d3, d2, d1, d0, {BIN_W{1'b0}}};
                cnt_q      <= '0;
                err_pend_q <= digit_invalid(d3) | digit_invalid(d2)
                            | digit_invalid(d1) | digit_invalid(d0);
            end else if (state_q == CONV) begin
                work_q <= work_next;
                cnt_q  <= cnt_q + 1'b1;
            end
            // Result is taken from the post-shift value of the final iteration
            if (last_iter) begin
                binary_q <= err_pend_q ? '0 : work_next[BIN_W-1:0];
                err_q    <= err_pend_q;
            end
        end
    end

    assign busy   = (state_q == CONV);
    assign done   = (state_q == DONE);
    assign binary = binary_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bcd4_to_binary_seq.sv
// Directed, table-driven bench for bcd4_to_binary_seq with hand-computed results
// plus sequences for ignored starts, asynchronous reset and back-to-back operation.
module tb_bcd4_to_binary_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  d0, d1, d2, d3;
    logic        busy;
    logic        done;
    logic [15:0] binary;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  d3, d2, d1, d0;
        logic [15:0] exp_bin;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    bcd4_to_binary_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .d0     (d0),
        .d1     (d1),
        .d2     (d2),
        .d3     (d3),
        .busy   (busy),
        .done   (done),
        .binary (binary),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one conversion and check latency, result and single-cycle done
    task automatic run_conv(input logic [3:0] a3, input logic [3:0] a2,
                            input logic [3:0] a1, input logic [3:0] a0,
                            input logic [15:0] eb, input logic ee);
        int n;
        @(negedge clk);
        d3 = a3; d2 = a2; d1 = a1; d0 = a0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd17);
        chk("binary", 32'(binary), 32'(eb));
        chk("err", 32'(err), 32'(ee));
        @(negedge clk);
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("binary_hold", 32'(binary), 32'(eb));
    endtask

    initial begin
        int n;
        int first_done;
        int n_done;

        vecs[0] = '{4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0};
        vecs[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 16'h270F, 1'b0};
        vecs[2] = '{4'd1, 4'd2, 4'd3, 4'd4, 16'h04D2, 1'b0};
        vecs[3] = '{4'd0, 4'd0, 4'd4, 4'd2, 16'h002A, 1'b0};
        vecs[4] = '{4'd0, 4'd0, 4'hA, 4'd0, 16'h0000, 1'b1};
        vecs[5] = '{4'd5, 4'd0, 4'd0, 4'd0, 16'h1388, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_binary", 32'(binary), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_conv(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0,
                     vecs[i].exp_bin, vecs[i].exp_err);

        // start re-pulsed mid-conversion with different digits must be ignored
        @(negedge clk);
        d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_done = 0;
        n_done = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 3 || k == 10) begin
                d3 = 4'd9; d2 = 4'd9; d1 = 4'd9; d0 = 4'd9;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = k;
                    chk("ign_binary", 32'(binary), 32'h04D2);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("ign_first_done", 32'(first_done), 32'd17);
        chk("ign_done_count", 32'(n_done), 32'd1);

        // asynchronous reset in the middle of iteration 8
        @(negedge clk);
        d3 = 4'd0; d2 = 4'd0; d1 = 4'd4; d0 = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_binary", 32'(binary), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("arst_no_done", 32'(n_done), 32'd0);
        run_conv(4'd0, 4'd0, 4'd0, 4'd7, 16'h0007, 1'b0);

        // start held high: one result every 17 cycles
        @(negedge clk);
        d3 = 4'd0; d2 = 4'd1; d1 = 4'd0; d0 = 4'd0;
        start = 1'b1;
        @(negedge clk);
        for (n = 1; n <= 51; n++) begin
            chk($sformatf("b2b_done_%0d", n), 32'(done), 32'((n % 17) == 0));
            chk($sformatf("b2b_busy_%0d", n), 32'(busy), 32'((n % 17) != 0));
            if ((n % 17) == 0)
                chk($sformatf("b2b_binary_%0d", n), 32'(binary), 32'h0064);
            if (n == 51) start = 1'b0;
            @(negedge clk);
        end
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_idle_done", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
